// File: rtl/puf2usrp.sv
// puf2usrp: 2^FIFO_AWIDTH-deep I/Q sample buffer that cuts a continuous stream into SPP-sample packets.
// Optional macro PUF2USRP_EARLY_TLAST_EN lets a stored in_tlast close a packet early.
module puf2usrp #(
    parameter int DATA_WIDTH  = 16,
    parameter int SPP         = 64,
    parameter int FIFO_AWIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tvalid,
    input  logic                    in_tlast,
    output logic                    in_tready,
    output logic [2*DATA_WIDTH-1:0] out_tdata,
    output logic                    out_tvalid,
    output logic                    out_tlast,
    input  logic                    out_tready
);

    localparam int DEPTH    = 1 << FIFO_AWIDTH;
    localparam int BEAT_W   = $clog2(SPP);
    localparam logic [FIFO_AWIDTH:0] FULL_COUNT = (FIFO_AWIDTH + 1)'(DEPTH);
    localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(SPP - 1);

    logic [2*DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AWIDTH-1:0]  wr_ptr;
    logic [FIFO_AWIDTH-1:0]  rd_ptr;
    logic [FIFO_AWIDTH:0]    occupancy;
    logic [BEAT_W-1:0]       beat;
    logic                    ready_en;
    logic                    push;
    logic                    pop;
    logic                    at_last;

    // ready_en keeps in_tready low during reset and raises it on the first edge after release
    assign in_tready  = ready_en && (occupancy < FULL_COUNT);
    assign out_tvalid = (occupancy != '0);
    assign out_tdata  = mem[rd_ptr];
    assign out_tlast  = out_tvalid && at_last;

    assign push = in_tvalid && in_tready;
    assign pop  = out_tvalid && out_tready;

`ifdef PUF2USRP_EARLY_TLAST_EN
    logic last_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            last_mem[wr_ptr] <= in_tlast;
        end
    end

    assign at_last = (beat == LAST_BEAT) || last_mem[rd_ptr];
`else
    logic unused_in_tlast;

    assign unused_in_tlast = in_tlast;
    assign at_last         = (beat == LAST_BEAT);
`endif

    // NOTE: sample storage has no reset; occupancy gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            beat      <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                beat   <= at_last ? '0 : beat + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_puf2usrp.sv
// Directed bench for puf2usrp: a queue model predicts ready/valid/last/data every cycle.
module tb_puf2usrp;

    localparam int DW    = 16;
    localparam int SPP   = 64;
    localparam int DEPTH = 32;
`ifdef PUF2USRP_EARLY_TLAST_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2*DW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic          in_tready;
    logic [2*DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tready = 1'b0;

    puf2usrp #(.DATA_WIDTH(DW), .SPP(SPP), .FIFO_AWIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_tdata  (in_tdata),
        .in_tvalid (in_tvalid),
        .in_tlast  (in_tlast),
        .in_tready (in_tready),
        .out_tdata (out_tdata),
        .out_tvalid(out_tvalid),
        .out_tlast (out_tlast),
        .out_tready(out_tready)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          last_q[$];
    int          model_beat = 0;
    bit          model_ready = 1'b0;
    bit          pushed = 1'b0;
    int          dut_accepts = 0;
    int          dut_tlasts = 0;
    int          out_idx = 0;
    int          first_tlast = -1;
    int          sent = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance model and clock together
    task automatic cycle();
        bit m_valid;
        bit m_last;
        #1;
        m_valid = (exp_q.size() != 0);
        m_last  = m_valid && ((model_beat == SPP - 1) || (EARLY && last_q[0]));
        check("in_tready", 32'(in_tready), 32'(model_ready && (exp_q.size() < DEPTH)));
        check("out_tvalid", 32'(out_tvalid), 32'(m_valid));
        check("out_tlast", 32'(out_tlast), 32'(m_last));
        if (m_valid) check("out_tdata", out_tdata, exp_q[0]);
        if (in_tvalid && in_tready) dut_accepts++;
        if (out_tvalid && out_tready && out_tlast) begin
            dut_tlasts++;
            if (first_tlast < 0) first_tlast = out_idx;
        end
        pushed = in_tvalid && model_ready && (exp_q.size() < DEPTH);
        if (m_valid && out_tready) begin
            void'(exp_q.pop_front());
            void'(last_q.pop_front());
            model_beat = m_last ? 0 : model_beat + 1;
            out_idx++;
        end
        if (pushed) begin
            exp_q.push_back(in_tdata);
            last_q.push_back(in_tlast);
        end
        @(negedge clk);
        model_ready = reset;
    endtask

    task automatic send_seq(input int n, input int duty_pct, input bit rand_data,
                            input logic [31:0] base, input int tlast_idx, input int budget,
                            output int n_sent);
        int          cyc = 0;
        logic [31:0] d;
        n_sent = 0;
        d = $urandom();
        while (n_sent < n && cyc < budget) begin
            in_tvalid = ($urandom_range(0, 99) < duty_pct);
            in_tdata  = rand_data ? d : base + 32'(n_sent);
            in_tlast  = (n_sent == tlast_idx);
            cycle();
            if (pushed) begin
                n_sent++;
                d = $urandom();
            end
            cyc++;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        out_tready = 1'b1;
        while (exp_q.size() != 0 && cyc < budget) begin
            cycle();
            cyc++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic new_phase();
        dut_accepts = 0;
        dut_tlasts  = 0;
        out_idx     = 0;
        first_tlast = -1;
    endtask

    initial begin
        // Reset held for 50 cycles
        repeat (50) cycle();
        reset = 1'b1;

        // Continuous stream of 256 counting samples
        new_phase();
        out_tready = 1'b1;
        send_seq(256, 100, 1'b0, 32'h0001_0000, -1, 400, sent);
        check("seq_sent", 32'(sent), 32'd256);
        drain(50);
        check("seq_tlast_count", 32'(dut_tlasts), 32'd4);
        check("seq_first_tlast", 32'(first_tlast), 32'd63);

        // Irregular input, random data
        new_phase();
        send_seq(8192, 50, 1'b1, 32'h0, -1, 40000, sent);
        check("rand_sent", 32'(sent), 32'd8192);
        drain(50);
        check("rand_tlast_count", 32'(dut_tlasts), 32'd128);

        // Back-pressure: 40 offered, only 32 fit, head sample held
        new_phase();
        out_tready = 1'b0;
        send_seq(40, 100, 1'b0, 32'h0003_0000, -1, 45, sent);
        check("fill_accepts", 32'(dut_accepts), 32'd32);
        check("full_ready_low", 32'(in_tready), 32'd0);
        check("hold_sample0", out_tdata, 32'h0003_0000);
        drain(50);

        // Full buffer: read happens, write refused, then accepted next cycle
        out_tready = 1'b0;
        send_seq(32, 100, 1'b0, 32'h0004_0000, -1, 40, sent);
        new_phase();
        in_tvalid  = 1'b1;
        in_tdata   = 32'h0004_0020;
        out_tready = 1'b1;
        cycle();
        check("refused_when_full", 32'(dut_accepts), 32'd0);
        check("ready_after_read", 32'(in_tready), 32'd1);
        cycle();
        check("accepted_next", 32'(dut_accepts), 32'd1);
        in_tvalid = 1'b0;
        drain(50);

        // Reset in the middle of a packet
        send_seq(10, 100, 1'b0, 32'h0005_0000, -1, 20, sent);
        check("pre_reset_valid", 32'(out_tvalid), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        last_q.delete();
        model_beat  = 0;
        model_ready = 1'b0;
        #1;
        check("reset_async_valid", 32'(out_tvalid), 32'd0);
        check("reset_async_tlast", 32'(out_tlast), 32'd0);
        check("reset_async_ready", 32'(in_tready), 32'd0);
        repeat (3) cycle();
        reset = 1'b1;
        new_phase();
        send_seq(64, 100, 1'b0, 32'h0006_0000, -1, 100, sent);
        drain(50);
        check("post_reset_tlasts", 32'(dut_tlasts), 32'd1);
        check("post_reset_first_tlast", 32'(first_tlast), 32'd63);

        // in_tlast on sample 9: early close only when the feature is built in
        new_phase();
        send_seq(80, 100, 1'b0, 32'h0007_0000, 9, 120, sent);
        drain(50);
        check("early_first_tlast", 32'(first_tlast), EARLY ? 32'd9 : 32'd63);
        check("early_tlast_count", 32'(dut_tlasts), EARLY ? 32'd2 : 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/puf2usrp.md
PUF2USRP -- requirements
Module: puf2usrp

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the width of one I or Q component.
REQ-002 Parameter SPP, default 64, is the number of samples per output packet (range 2..65535).
REQ-003 Parameter FIFO_AWIDTH, default 5, gives a buffer depth of 2^FIFO_AWIDTH samples (32).
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_tdata  input  2*DATA_WIDTH  sample, I in [2*DATA_WIDTH-1:DATA_WIDTH], Q in [DATA_WIDTH-1:0].
REQ-007 in_tvalid  input  1  input sample valid.
REQ-008 in_tlast  input  1  input end-of-burst marker (used only per REQ-024).
REQ-009 in_tready  output  1  buffer can accept a sample.
REQ-010 out_tdata  output  2*DATA_WIDTH  output sample, same I/Q packing.
REQ-011 out_tvalid  output  1  output sample valid.
REQ-012 out_tlast  output  1  last sample of the output packet.
REQ-013 out_tready  input  1  downstream accepts a sample.

Function
REQ-014 Input transfer occurs on a rising edge when in_tvalid and in_tready are both 1; output transfer occurs when out_tvalid and out_tready are both 1.
REQ-015 in_tready = 1 when buffer occupancy < 2^FIFO_AWIDTH; a write is refused when the buffer is full, even if a read happens in the same cycle.
REQ-016 Samples leave in arrival order, bit-exact (I and Q unmodified), with no loss and no duplication.
REQ-017 Latency: a sample written at edge k into an empty buffer drives out_tdata with out_tvalid = 1 after edge k+1; it is never presented combinationally from in_tdata.
REQ-018 out_tvalid = 1 exactly when occupancy > 0; out_tdata is held stable while out_tvalid = 1 and out_tready = 0.
REQ-019 A simultaneous read and write on a non-full, non-empty buffer leaves occupancy unchanged.
REQ-020 A beat counter counts output transfers from 0; out_tlast = out_tvalid AND (count == SPP-1).
REQ-021 On a transfer with out_tlast = 1 the counter returns to 0; otherwise it increments on each output transfer; it does not change when there is no transfer.
REQ-022 Gaps in in_tvalid (irregular input) do not affect packet boundaries; packets span gaps.

Reset
REQ-023 While reset = 0: occupancy = 0, read and write pointers = 0, beat counter = 0, out_tvalid = 0, out_tlast = 0, in_tready = 0. Reset mid-packet discards buffered data and the partial packet. After release, in_tready = 1 from the first edge and the first output sample starts a new packet.

Configuration
REQ-024 Macro PUF2USRP_EARLY_TLAST_EN.
- Defined: in_tlast is stored with each sample; out_tlast = out_tvalid AND (stored last OR count == SPP-1); the counter resets after either condition.
- Undefined: in_tlast is ignored and no storage is added for it.

Verification
REQ-025 Reset held low for 50 cycles, then released, in_tvalid = 1 with in_tdata = 0x0001_0000 + n for n = 0..255, out_tready = 1 -> outputs in the same order; out_tlast on samples 63, 127, 191, 255; first out_tvalid one cycle after first accept.
REQ-026 in_tvalid pseudo-random (about 50% duty), 8192 samples, out_tready = 1 -> output sequence equals the input sequence; out_tlast on every 64th output sample.
REQ-027 out_tready = 0 while 40 samples are offered -> in_tready drops after 32 accepts, out_tdata holds sample 0; out_tready = 1 afterwards -> all 32 samples drain in order.
REQ-028 Full buffer with out_tready = 1 and in_tvalid = 1 -> the read occurs, the write is refused that cycle, and the write is accepted the next cycle.
REQ-029 reset asserted after 10 samples of a packet -> outputs go to reset values immediately; the next 64 samples form one packet with out_tlast on the 64th.
REQ-030 With PUF2USRP_EARLY_TLAST_EN defined: in_tlast on input sample 9 -> out_tlast on output sample 9, and the next out_tlast falls 64 samples later. Without the macro: out_tlast falls only on sample 63.
